// File: rtl/up_counter.sv
// up_counter: parameterised binary up/down counter with asynchronous active-low reset,
// synchronous clear/load/enable, a combinational terminal-count flag and a registered
// wrap pulse.
//
// Build option: define COUNTER_SATURATE_EN to make the counter stop at its limit
// (all-ones counting up, zero counting down) instead of wrapping. In that build wrap
// never asserts.
module up_counter #(
  parameter int unsigned            CNTR_WIDTH = 4,
  parameter logic [CNTR_WIDTH-1:0]  RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CNTR_WIDTH-1:0] load_val,
  input  logic                  up,
  output logic [CNTR_WIDTH-1:0] cntr,
  output logic                  tc,
  output logic                  wrap
);

  // Reject widths outside the supported range at elaboration time.
  if (CNTR_WIDTH < 1 || CNTR_WIDTH > 32) begin : gen_bad_width
    $error("up_counter: CNTR_WIDTH must be in 1..32");
  end

  localparam logic [CNTR_WIDTH-1:0] One = CNTR_WIDTH'(1);

  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic                  wrap_q, wrap_d;
  logic                  all_ones;
  logic                  is_zero;

  assign all_ones = &cntr_q;
  assign is_zero  = ~|cntr_q;

  // Next-state selection: clear beats load beats counting; disabled counting holds.
  always_comb begin
    cntr_d = cntr_q;
    wrap_d = 1'b0;
    if (clr) begin
      cntr_d = RST_VAL;
    end else if (load) begin
      cntr_d = load_val;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      // Hold at the limit in the direction of travel; never flag a wrap.
      if (up) begin
        if (!all_ones) cntr_d = cntr_q + One;
      end else begin
        if (!is_zero) cntr_d = cntr_q - One;
      end
`else
      // Modulo arithmetic; the carry/borrow out only drives the wrap pulse.
      if (up) begin
        cntr_d = cntr_q + One;
        wrap_d = all_ones;
      end else begin
        cntr_d = cntr_q - One;
        wrap_d = is_zero;
      end
`endif
    end
  end

  // State registers with asynchronous reset to the configured start value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr_q <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      wrap_q <= wrap_d;
    end
  end

  // Outputs: tc is purely combinational on the current count and direction.
  always_comb begin
    cntr = cntr_q;
    tc   = up ? all_ones : is_zero;
`ifdef COUNTER_SATURATE_EN
    wrap = 1'b0;
`else
    wrap = wrap_q;
`endif
  end

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter (CNTR_WIDTH=4, RST_VAL=0). A reference model
// pushes the expected post-edge state into a scoreboard queue when inputs are driven;
// entries are popped and compared one time unit after the clock edge.
module tb_up_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         up;
  logic [W-1:0] cntr;
  logic         tc;
  logic         wrap;

  typedef struct {
    logic [W-1:0] cntr;
    logic         wrap;
  } exp_t;

  exp_t sb_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state.
  bit [W-1:0] m_cntr;
  bit         m_wrap;

  up_counter #(
    .CNTR_WIDTH (W),
    .RST_VAL    (4'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .cntr     (cntr),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tc(input logic [W-1:0] c, input logic dir);
    return dir ? (c == {W{1'b1}}) : (c == '0);
  endfunction

  // Advance the model by one edge, push its prediction, clock the DUT and compare.
  task automatic cycle(input string tag);
    exp_t e;
    bit [W-1:0] nxt;
    bit         w;
    nxt = m_cntr;
    w   = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      nxt = load_val;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (up) nxt = (m_cntr == 4'hF) ? m_cntr : m_cntr + 4'd1;
      else    nxt = (m_cntr == 4'h0) ? m_cntr : m_cntr - 4'd1;
`else
      if (up) begin
        nxt = m_cntr + 4'd1;
        w   = (m_cntr == 4'hF);
      end else begin
        nxt = m_cntr - 4'd1;
        w   = (m_cntr == 4'h0);
      end
`endif
    end
    m_cntr = nxt;
    m_wrap = w;
    e.cntr = nxt;
    e.wrap = w;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val({tag, ".cntr"}, 32'(cntr), 32'(e.cntr));
    check_val({tag, ".wrap"}, 32'(wrap), 32'(e.wrap));
    check_val({tag, ".tc"},   32'(tc),   32'(exp_tc(e.cntr, up)));
  endtask

  // Assert reset between edges and confirm the immediate effect.
  task automatic async_reset(input string tag, input int unsigned edges);
    rst_n = 1'b0;
    #1;
    m_cntr = '0;
    m_wrap = 1'b0;
    check_val({tag, ".cntr"}, 32'(cntr), 32'd0);
    check_val({tag, ".wrap"}, 32'(wrap), 32'd0);
    for (int i = 0; i < int'(edges); i++) begin
      @(posedge clk);
      #1;
      check_val({tag, ".held"}, 32'(cntr), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    up       = 1'b1;
    m_cntr   = '0;
    m_wrap   = 1'b0;

    // Reset state before any clock edge.
    #2;
    check_val("rst0.cntr", 32'(cntr), 32'd0);
    check_val("rst0.wrap", 32'(wrap), 32'd0);
    check_val("rst0.tc",   32'(tc),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First edge after release counts to 1, then free-run.
    cycle("first");
    check_val("first.is1", 32'(cntr), 32'd1);
    for (int i = 0; i < 9; i++) cycle("run10");

    // Reset pulse for two cycles, then 100 cycles of free-run (several wraps).
    async_reset("pulse", 2);
    for (int i = 0; i < 100; i++) cycle("free");

    // Mid-count async reset at cntr=9, then resume from 0.
    for (int i = 0; i < 16 && m_cntr != 4'd9; i++) cycle("to9");
    check_val("at9", 32'(cntr), 32'd9);
    async_reset("mid", 0);
    cycle("resume");
    check_val("resume.is1", 32'(cntr), 32'd1);

    // Enable gating at 5.
    for (int i = 0; i < 16 && m_cntr != 4'd5; i++) cycle("to5");
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold");
    check_val("hold.is5", 32'(cntr), 32'd5);
    en = 1'b1;
    cycle("reen");
    check_val("reen.is6", 32'(cntr), 32'd6);

    // Load and clear priority.
    load = 1'b1;
    load_val = 4'd12;
    cycle("load12");
    check_val("load12.val", 32'(cntr), 32'd12);
    clr = 1'b1;
    cycle("clr_load");
    check_val("clr_load.val", 32'(cntr), 32'd0);
    clr = 1'b0;
    load_val = 4'd15;
    cycle("load15");
    cycle("reload15");
    load = 1'b0;

    // Down count from 1 through zero and wrap to 15.
    load = 1'b1;
    load_val = 4'd1;
    cycle("load1");
    load = 1'b0;
    up = 1'b0;
    cycle("down0");
    cycle("down15");
    cycle("down14");
    up = 1'b1;

`ifdef COUNTER_SATURATE_EN
    // Saturation at all-ones.
    load = 1'b1;
    load_val = 4'd13;
    cycle("load13");
    load = 1'b0;
    for (int i = 0; i < 5; i++) cycle("sat");
    check_val("sat.is15", 32'(cntr), 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
